// File: rtl/fixed_point_bias_add.sv
// Element-wise signed fixed-point bias add with round-half-up and saturation.
// The data and bias streams are joined, summed in stage 1 at the finer of the
// two input formats, then converted to the output format in stage 2. A beat
// counter marks the last beat of every bias vector.
module fixed_point_bias_add #(
  parameter int unsigned DATA_IN_PRECISION_0  = 16,
  parameter int unsigned DATA_IN_PRECISION_1  = 3,
  parameter int unsigned BIAS_PRECISION_0     = 16,
  parameter int unsigned BIAS_PRECISION_1     = 3,
  parameter int unsigned DATA_OUT_PRECISION_0 = 16,
  parameter int unsigned DATA_OUT_PRECISION_1 = 3,
  parameter int unsigned TENSOR_SIZE_DIM_0    = 32,
  parameter int unsigned PARALLELISM_DIM_0    = 1,
  parameter int unsigned PARALLELISM_DIM_1    = 1,
  parameter int unsigned BIAS_DEPTH           = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_IN_PRECISION_0-1:0]  data_in [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  input  logic [BIAS_PRECISION_0-1:0]     bias [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
  input  logic                            bias_valid,
  output logic                            bias_ready,
  output logic [DATA_OUT_PRECISION_0-1:0] data_out [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
  output logic                            data_out_valid,
  input  logic                            data_out_ready,
  output logic                            data_out_last
);

  localparam int unsigned P      = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int unsigned F      = (DATA_IN_PRECISION_1 > BIAS_PRECISION_1) ?
                                   DATA_IN_PRECISION_1 : BIAS_PRECISION_1;
  localparam int unsigned DiInt  = DATA_IN_PRECISION_0 - DATA_IN_PRECISION_1;
  localparam int unsigned BInt   = BIAS_PRECISION_0 - BIAS_PRECISION_1;
  localparam int unsigned IntW   = (DiInt > BInt) ? DiInt : BInt;
  // One guard bit on top of the aligned operands: the sum can never overflow.
  localparam int unsigned SumW   = IntW + F + 1;
  localparam int unsigned ShDi   = F - DATA_IN_PRECISION_1;
  localparam int unsigned ShB    = F - BIAS_PRECISION_1;
  localparam int unsigned RndK   = (DATA_OUT_PRECISION_1 < F) ? F - DATA_OUT_PRECISION_1 : 0;
  localparam int unsigned RndSh  = (RndK > 0) ? RndK - 1 : 0;
  localparam int unsigned ShOut  = (DATA_OUT_PRECISION_1 > F) ? DATA_OUT_PRECISION_1 - F : 0;
  // Extra bit for the rounding add, plus room for any left shift, plus a sign
  // bit so the saturation bounds are representable.
  localparam int unsigned ConvW  = SumW + 1 + ShOut;
  localparam int unsigned WideW  = ((ConvW > DATA_OUT_PRECISION_0) ?
                                    ConvW : DATA_OUT_PRECISION_0) + 1;
  localparam int unsigned CntW   = (BIAS_DEPTH > 1) ? $clog2(BIAS_DEPTH) : 1;

  localparam logic signed [WideW-1:0] RndAdd = (RndK > 0) ? (WideW'(1) << RndSh) : '0;
  localparam logic signed [WideW-1:0] OutMax =
      (WideW'(1) << (DATA_OUT_PRECISION_0 - 1)) - WideW'(1);
  localparam logic signed [WideW-1:0] OutMin = ~OutMax;

  logic                            s1_valid_q;
  logic                            s1_last_q;
  logic signed [SumW-1:0]          s1_sum_q [P];
  logic                            out_valid_q;
  logic                            out_last_q;
  logic [DATA_OUT_PRECISION_0-1:0] out_data_q [P];
  logic [CntW-1:0]                 cnt_q;

  logic                            s1_ready;
  logic                            s2_ready;
  logic                            fire;
  logic                            cnt_last;
  logic signed [SumW-1:0]          a_ext [P];
  logic signed [SumW-1:0]          b_ext [P];
  logic signed [SumW-1:0]          sum_d [P];
  logic signed [WideW-1:0]         wide [P];
  logic [DATA_OUT_PRECISION_0-1:0] conv_d [P];

  assign s2_ready      = !out_valid_q || data_out_ready;
  assign s1_ready      = !s1_valid_q || s2_ready;
  assign data_in_ready = bias_valid && s1_ready;
  assign bias_ready    = data_in_valid && s1_ready;
  assign fire          = data_in_valid && bias_valid && s1_ready;
  assign cnt_last      = (cnt_q == CntW'(BIAS_DEPTH - 1));

  assign data_out       = out_data_q;
  assign data_out_valid = out_valid_q;
  assign data_out_last  = out_last_q;

  // Align both operands to F fractional bits and sum them.
  always_comb begin
    for (int unsigned i = 0; i < P; i++) begin
      a_ext[i] = {{(SumW - DATA_IN_PRECISION_0){data_in[i][DATA_IN_PRECISION_0-1]}},
                  data_in[i]} << ShDi;
      b_ext[i] = {{(SumW - BIAS_PRECISION_0){bias[i][BIAS_PRECISION_0-1]}},
                  bias[i]} << ShB;
      sum_d[i] = a_ext[i] + b_ext[i];
    end
  end

  // Round half-up (or widen) to the output format, then saturate.
  always_comb begin
    for (int unsigned i = 0; i < P; i++) begin
      wide[i] = {{(WideW - SumW){s1_sum_q[i][SumW-1]}}, s1_sum_q[i]};
      wide[i] = (wide[i] + RndAdd) >>> RndK;
      wide[i] = wide[i] <<< ShOut;
      if (wide[i] > OutMax) begin
        conv_d[i] = OutMax[DATA_OUT_PRECISION_0-1:0];
      end else if (wide[i] < OutMin) begin
        conv_d[i] = OutMin[DATA_OUT_PRECISION_0-1:0];
      end else begin
        conv_d[i] = wide[i][DATA_OUT_PRECISION_0-1:0];
      end
    end
  end

  // Stage 1: capture the sum and its last flag on fire; advance the beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '{default: '0};
      cnt_q      <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= fire;
      end
      if (fire) begin
        s1_sum_q  <= sum_d;
        s1_last_q <= cnt_last;
        cnt_q     <= cnt_last ? '0 : cnt_q + CntW'(1);
      end
    end
  end

  // Stage 2: output register, held stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '{default: '0};
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= conv_d;
        out_last_q <= s1_last_q;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_bias_add.sv
// Bench for fixed_point_bias_add: a default-format instance and a second one
// with one output fractional bit, driven by the same streams and checked
// against a real-valued reference of add, round-half-up and clamp.
module tb_fixed_point_bias_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] din [1];
  logic [15:0] bin [1];
  logic        din_valid, bias_valid, out_ready;
  logic        din_ready, bias_ready, out_valid, out_last;
  logic [15:0] dout [1];
  logic        din_ready_r, bias_ready_r, out_valid_r, out_last_r;
  logic [15:0] dout_r [1];

  fixed_point_bias_add u_dut (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(din_valid), .data_in_ready(din_ready),
    .bias(bin), .bias_valid(bias_valid), .bias_ready(bias_ready),
    .data_out(dout), .data_out_valid(out_valid), .data_out_ready(out_ready),
    .data_out_last(out_last)
  );

  fixed_point_bias_add #(.DATA_OUT_PRECISION_1(1)) u_dut_r (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(din_valid), .data_in_ready(din_ready_r),
    .bias(bin), .bias_valid(bias_valid), .bias_ready(bias_ready_r),
    .data_out(dout_r), .data_out_valid(out_valid_r), .data_out_ready(out_ready),
    .data_out_last(out_last_r)
  );

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t q3[$];
  exp_t q1[$];
  int   idx3 = 0, idx1 = 0;
  int   last_seen = 0, n_out = 0;
  logic st_prev = 1'b0;
  logic [15:0] st_d;
  logic st_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value = (d + b) / 8, scaled to frac_out bits, rounded half-up, clamped.
  function automatic logic [15:0] ref_out(input logic [15:0] d, input logic [15:0] b,
                                          input int frac_out);
    int  s;
    real y;
    s = int'($signed(d)) + int'($signed(b));
    y = $floor(real'(s) / 8.0 * ((frac_out == 3) ? 8.0 : 2.0) + 0.5);
    if (y > 32767.0) y = 32767.0;
    if (y < -32768.0) y = -32768.0;
    return 16'($rtoi(y));
  endfunction

  // One clock: check at negedge, then advance past the posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (!bias_valid) chk("din_ready_no_bias", din_ready, 0);
      if (!din_valid) chk("bias_ready_no_data", bias_ready, 0);
      if (din_valid && bias_valid) chk("ready_pair", din_ready, bias_ready);
      if (st_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", dout[0], st_d);
        chk("stall_last", out_last, st_l);
      end
      st_prev = out_valid && !out_ready;
      st_d    = dout[0];
      st_l    = out_last;
      if (out_valid && out_ready) begin
        if (q3.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          e = q3.pop_front();
          chk("data3", dout[0], e.d);
          chk("last3", out_last, e.l);
          if (out_last) last_seen++;
          n_out++;
        end
      end
      if (out_valid_r && out_ready) begin
        if (q1.size() == 0) chk("spurious_out_r", out_valid_r, 0);
        else begin
          e = q1.pop_front();
          chk("data1", dout_r[0], e.d);
          chk("last1", out_last_r, e.l);
        end
      end
      if (din_valid && bias_valid && din_ready) begin
        q3.push_back('{d: ref_out(din[0], bin[0], 3), l: (idx3 % 32) == 31});
        idx3++;
      end
      if (din_valid && bias_valid && din_ready_r) begin
        q1.push_back('{d: ref_out(din[0], bin[0], 1), l: (idx1 % 32) == 31});
        idx1++;
      end
    end
    @(posedge clk);
    if (rst) begin
      q3.delete();
      q1.delete();
      idx3 = 0;
      idx1 = 0;
      st_prev = 1'b0;
    end
    #1;
  endtask

  task automatic directed(input logic [15:0] d, input logic [15:0] b,
                          input logic [15:0] e3, input logic [15:0] e1, input string tag);
    din[0] = d; bin[0] = b; din_valid = 1'b1; bias_valid = 1'b1; out_ready = 1'b1;
    step();
    din_valid = 1'b0; bias_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 0);
    step();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_d3"}, dout[0], e3);
    chk({tag, "_d1"}, dout_r[0], e1);
    step();
    chk({tag, "_pulse"}, out_valid, 0);
  endtask

  task automatic rand_data();
    din[0] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
    bin[0] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; bias_valid = 1'b0; out_ready = 1'b1;
    din[0] = '0; bin[0] = '0;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", dout[0], 0);
    chk("rst_data_r", dout_r[0], 0);
    rst = 1'b0;

    directed(16'h0010, 16'h0008, 16'h0018, 16'h0006, "basic");
    directed(16'h7FF0, 16'h0020, 16'h7FFF, 16'h2004, "sat_pos");
    directed(16'h8008, 16'hFFF0, 16'h8000, 16'hDFFE, "sat_neg");
    directed(16'h0006, 16'h0000, 16'h0006, 16'h0002, "rnd_6");
    directed(16'h0005, 16'h0000, 16'h0005, 16'h0001, "rnd_5");
    directed(16'hFFFD, 16'h0000, 16'hFFFD, 16'hFFFF, "rnd_neg");

    // Lone bias valid must never be consumed.
    bias_valid = 1'b1; din_valid = 1'b0; bin[0] = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("lone_bias_ready", bias_ready, 0);
      chk("lone_no_out", out_valid, 0);
    end
    bias_valid = 1'b0;

    // 64 back-to-back beats after a fresh reset: last on beats 31 and 63.
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_seen = 0; n_out = 0;
    din_valid = 1'b1; bias_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rand_data();
      step();
    end
    din_valid = 1'b0; bias_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("last_count64", last_seen, 2);
    chk("beats64", n_out, 64);

    // Fill both stages, reset, then the next vector must flag its beat 31.
    din_valid = 1'b1; bias_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step();
    end
    chk("full_valid", out_valid, 1);
    chk("full_no_accept", din_ready, 0);
    rst = 1'b1; din_valid = 1'b0; bias_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_valid_r", out_valid_r, 0);
    last_seen = 0; n_out = 0;
    out_ready = 1'b1; din_valid = 1'b1; bias_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rand_data();
      step();
    end
    din_valid = 1'b0; bias_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("last_after_rst", last_seen, 1);
    chk("beats_after_rst", n_out, 32);

    // Random valids and backpressure against the reference queues.
    for (int i = 0; i < 600; i++) begin
      din_valid  = ($urandom_range(0, 9) < 7);
      bias_valid = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      rand_data();
      step();
    end
    din_valid = 1'b0; bias_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (q3.size() != 0 || q1.size() != 0); i++) step();
    chk("drain_q3", q3.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
